lr3_scan_ctrl: RTL
==================

Name: lr3_scan_ctrl

Overview:
Entry and display-scan controller for the LR3 hex-entry board. It captures hex digits strobed by BTN_CE into an 8-digit buffer. It time-multiplexes that buffer onto the 8-digit common-anode 7-segment display, advancing one digit per DISP_CE tick. Digit slots that hold no entry are blanked, and a short anti-ghost dead time is inserted at every digit change.

Parameters:
- DEAD_CYC, 2, CLK cycles with all anodes off after each scan advance (0 = none); must be less than the DISP_CE period.
- NDIG, 8, number of display digits (fixed at 8 for LR3; AN width follows).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- BTN_CE  in  1  one-cycle strobe: capture DAT_I as a new digit.
- DAT_I  in  4  hex digit to capture.
- DISP_CE  in  1  one-cycle scan-advance tick.
- CLR  in  1  synchronous clear of the entry buffer (scan keeps running).
- CAT  out  7  segment cathodes, active low; CAT[0]=a … CAT[6]=g.
- AN  out  8  digit anodes, active low, one-hot or all ones; AN[0] is the rightmost digit.
- DIG_CNT  out  4  number of valid digits held, 0..8.
- FULL  out  1  high when DIG_CNT==8.

Behaviour:
- Reset (RST high at an edge) values:
  - AN=8'hFF, CAT=7'h7F, DIG_CNT=0, FULL=0.
  - buffer all zero, scan index=0, FSM=SHOW, dead counter=0.
  - RST overrides all other inputs, including mid-dead-time.
- Entry buffer: 8 nibbles, buf[0] is the rightmost digit.
  - BTN_CE at edge k: buf[i]<=buf[i-1] for i=1..7, buf[0]<=DAT_I, DIG_CNT<=min(DIG_CNT+1,8).
  - When FULL, the oldest digit buf[7] is discarded and DIG_CNT stays 8.
- CLR at edge k: buffer<=0, DIG_CNT<=0. CLR has priority over a simultaneous BTN_CE, and that BTN_CE is dropped.
- FULL is registered and equals (DIG_CNT==8) in the same cycle.
- Scan FSM:
  - SHOW:
    - Each cycle: AN<=~(1<<idx), CAT<=seg(buf[idx]).
    - If idx>=DIG_CNT (slot empty): AN<=8'hFF and CAT<=7'h7F instead.
    - DISP_CE at edge k: idx<=(idx+1) mod 8, AN<=8'hFF, CAT<=7'h7F. If DEAD_CYC>0, dead counter<=DEAD_CYC-1 and go to DEAD; if DEAD_CYC=0, stay in SHOW.
  - DEAD:
    - AN and CAT are held at all-off.
    - Dead counter decrements each cycle; when it reaches 0, go to SHOW.
    - New digit drive appears at edge k+DEAD_CYC+1.
    - DISP_CE during DEAD is ignored; the index does not advance.
- Buffer changes are visible on CAT one cycle after capture, in SHOW only.
- Simultaneous BTN_CE and DISP_CE: both take effect at the same edge. The next SHOW cycle uses the shifted buffer and the new index.
- The index wraps 7→0 with no gap beyond the normal dead time.
- Segment encoding seg(d), bit order g..a, 0 = lit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No combinational path from any input to AN or CAT; both are registered.

Test Plan:
Common setup: CLK period 10 ns; DISP_CE high for 1 cycle every 9 cycles; DEAD_CYC=2.
1. Reset and empty display:
   - Stimulus: RST high for 2 cycles, then scan 16 ticks with no entries.
   - Required: AN=FF and CAT=7F throughout; DIG_CNT=0; FULL=0.
2. Entry and blanking:
   - Stimulus: BTN_CE with DAT_I=2, then BTN_CE with DAT_I=3.
   - Required: DIG_CNT=2; buf[1]=2, buf[0]=3.
   - At idx0: AN=FE, CAT=0110000. At idx1: AN=FD, CAT=0100100.
   - At idx2..7: AN=FF.
3. Dead-time timing:
   - Stimulus: DISP_CE at edge k while in SHOW.
   - Required: AN=FF at edges k, k+1, k+2; new digit drive at edge k+3.
   - A DISP_CE at edge k+1 does not advance idx.
4. Overflow:
   - Stimulus: enter 9 digits 0,B,2,3,8,0,3,B,A.
   - Required: DIG_CNT=8, FULL=1.
   - Buffer buf7..buf0 = B,2,3,8,0,3,B,A; digit 0 discarded.
   - idx7 shows CAT=0000011, idx0 shows CAT=0001000.
5. CLR beats BTN_CE:
   - Stimulus: CLR and BTN_CE (DAT_I=F) asserted in the same cycle while FULL=1.
   - Required: DIG_CNT=0, FULL=0, all digits blank on the next scan pass.
6. Reset mid-DEAD and simultaneous events:
   - Stimulus: RST asserted during DEAD.
   - Required: next cycle AN=FF, idx=0, FSM=SHOW.
   - Stimulus: BTN_CE and DISP_CE at the same edge.
   - Required: after dead time, the new idx shows the shifted buffer contents.

Source files
------------

// File: rtl/lr3_scan_ctrl.sv
// lr3_scan_ctrl -- entry and display-scan controller for the LR3 hex-entry board.
//
// Purpose:
//   Captures hex digits into an 8-nibble shift buffer. Each new digit enters at
//   the rightmost position. The buffer is time-multiplexed onto a common-anode
//   7-segment display, one digit per DISP_CE tick. Slots that hold no entry are
//   blanked. After every scan advance, all anodes stay off for DEAD_CYC cycles
//   so that the previous digit's segments cannot ghost onto the next anode.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   BTN_CE   in   one-cycle strobe, captures DAT_I as a new digit
//   DAT_I    in   [3:0] hex digit to capture
//   DISP_CE  in   one-cycle scan-advance tick
//   CLR      in   synchronous clear of the entry buffer (scan keeps running)
//   CAT      out  [6:0] segment cathodes, active low, CAT[0]=a .. CAT[6]=g
//   AN       out  [NDIG-1:0] digit anodes, active low, AN[0] = rightmost digit
//   DIG_CNT  out  [3:0] number of valid digits held (0..8)
//   FULL     out  high when DIG_CNT == 8
module lr3_scan_ctrl #(
   parameter int DEAD_CYC = 2,
   parameter int NDIG     = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            BTN_CE,
   input  logic [3:0]      DAT_I,
   input  logic            DISP_CE,
   input  logic            CLR,
   output logic [6:0]      CAT,
   output logic [NDIG-1:0] AN,
   output logic [3:0]      DIG_CNT,
   output logic            FULL
);

   localparam int IW = $clog2(NDIG);
   localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

   typedef enum logic {SHOW, DEAD} state_t;

   // Segment pattern for one hex digit, bit order g..a, 0 = segment lit.
   function automatic logic [6:0] seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [3:0]      dig_q [NDIG];
   logic [3:0]      dig_d [NDIG];
   logic [3:0]      cnt_q, cnt_d;
   logic            full_q, full_d;
   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   dead_q, dead_d;
   logic [NDIG-1:0] an_q, an_d;
   logic [6:0]      cat_q, cat_d;

   // Entry buffer and digit count. CLR wins over a simultaneous BTN_CE.
   always_comb begin
      dig_d = dig_q;
      cnt_d = cnt_q;
      if (CLR) begin
         for (int i = 0; i < NDIG; i++) dig_d[i] = 4'h0;
         cnt_d = 4'd0;
      end else if (BTN_CE) begin
         // Shift left; the oldest digit falls off the top once full.
         for (int i = NDIG - 1; i > 0; i--) dig_d[i] = dig_q[i-1];
         dig_d[0] = DAT_I;
         if (cnt_q != 4'(NDIG)) cnt_d = cnt_q + 4'd1;
      end
      // FULL is registered from the next count so it tracks DIG_CNT exactly.
      full_d = (cnt_d == 4'(NDIG));
   end

   // Scan FSM. AN/CAT default to all-off; only a non-advancing SHOW cycle on
   // an occupied slot drives a digit. The drive uses the current buffer, so a
   // captured digit appears one cycle after its strobe.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dead_d  = dead_q;
      an_d    = '1;
      cat_d   = '1;
      case (state_q)
         SHOW: begin
            if (DISP_CE) begin
               idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
               if (DEAD_CYC > 0) begin
                  state_d = DEAD;
                  dead_d  = DW'(DEAD_CYC - 1);
               end
            end else if ({1'b0, idx_q} < cnt_q) begin
               an_d  = ~(NDIG'(1) << idx_q);
               cat_d = seg(dig_q[idx_q]);
            end
         end
         default: begin
            // DISP_CE is ignored here; the index only moves from SHOW.
            if (dead_q == '0) state_d = SHOW;
            else              dead_d  = dead_q - 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dig_q   <= '{default: 4'h0};
         cnt_q   <= 4'd0;
         full_q  <= 1'b0;
         state_q <= SHOW;
         idx_q   <= '0;
         dead_q  <= '0;
         an_q    <= '1;
         cat_q   <= '1;
      end else begin
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         dead_q  <= dead_d;
         an_q    <= an_d;
         cat_q   <= cat_d;
      end
   end

   assign CAT     = cat_q;
   assign AN      = an_q;
   assign DIG_CNT = cnt_q;
   assign FULL    = full_q;

endmodule
